// File: rtl/dsc_mul_ctrl_if.sv
// rtl/dsc_mul_ctrl_if.sv - request/result handshake and multiplier-side signals of the DSC multiplier sequencer
// slave is the sequencer; master is the host side that also provides the multiplier count.
interface dsc_mul_ctrl_if #(
    parameter int SNG_WIDTH = 6
);
    logic                     req_valid;
    logic                     req_ready;
    logic [SNG_WIDTH-1:0]     req_a;
    logic [SNG_WIDTH-1:0]     req_b;
    logic [SNG_WIDTH-1:0]     mul_a;
    logic [SNG_WIDTH-1:0]     mul_b;
    logic                     mul_clr;
    logic                     mul_en;
    logic [2*SNG_WIDTH-1:0]   mul_z;
    logic                     res_valid;
    logic                     res_ready;
    logic [2*SNG_WIDTH-1:0]   res_z;
    logic                     busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_z, res_ready,
        output req_ready, mul_a, mul_b, mul_clr, mul_en, res_valid, res_z, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_z, res_ready,
        input  req_ready, mul_a, mul_b, mul_clr, mul_en, res_valid, res_z, busy
    );
endinterface

// File: rtl/dsc_mul_ctrl.sv
// rtl/dsc_mul_ctrl.sv - sequencer for one DSC multiplier: latch, clear, run 2^(2*SNG_WIDTH) cycles, capture
// Optional DSC_MUL_CTRL_ZERO_SKIP_EN: zero operands bypass the run and complete with res_z=0 in one cycle.
module dsc_mul_ctrl #(
    parameter int SNG_WIDTH = 6
) (
    input  logic           clk,
    input  logic           rst,
    dsc_mul_ctrl_if.slave  bus
);
    localparam int PW = 2 * SNG_WIDTH;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] RUN_LAST = CW'((1 << PW) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SNG_WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [SNG_WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [PW-1:0]         res_z_q, res_z_d;
    logic                  req_ready_q, req_ready_d;
    logic                  busy_q, busy_d;
    logic                  mul_clr_q, mul_clr_d;
    logic                  mul_en_q, mul_en_d;
    logic                  res_valid_q, res_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        res_z_d = res_z_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    mul_a_d = bus.req_a;
                    mul_b_d = bus.req_b;
`ifdef DSC_MUL_CTRL_ZERO_SKIP_EN
                    if ((bus.req_a == '0) || (bus.req_b == '0)) begin
                        res_z_d = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CLR;
                    end
`else
                    state_d = S_CLR;
`endif
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == RUN_LAST) begin
                    state_d = S_SETTLE;
                end
            end
            // The multiplier's output counter has absorbed its last increment by now.
            S_SETTLE: begin
                res_z_d = bus.mul_z;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        mul_clr_d   = (state_d == S_CLR);
        mul_en_d    = (state_d == S_RUN);
        res_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            res_z_q     <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            mul_clr_q   <= 1'b0;
            mul_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            res_z_q     <= res_z_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            mul_clr_q   <= mul_clr_d;
            mul_en_q    <= mul_en_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.mul_clr   = mul_clr_q;
    assign bus.mul_en    = mul_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_z     = res_z_q;
endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// tb/tb_dsc_mul_ctrl.sv - directed bench for dsc_mul_ctrl with a clock-division DSC multiplier model
module tb_dsc_mul_ctrl;
    localparam int W  = 6;
    localparam int PW = 12;
    localparam int FULL_LAT = 4099;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dsc_mul_ctrl_if #(.SNG_WIDTH(W)) bus ();

    dsc_mul_ctrl #(.SNG_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row/column unary streams: over 4096 cycles exactly a*b coincident ones.
    logic [PW-1:0] m_idx;
    logic          m_bit;
    assign m_bit = (m_idx[W-1:0] < bus.mul_a) && (m_idx[PW-1:W] < bus.mul_b);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idx     <= '0;
            bus.mul_z <= '0;
        end else if (bus.mul_clr) begin
            m_idx     <= '0;
            bus.mul_z <= '0;
        end else if (bus.mul_en) begin
            m_idx     <= m_idx + 12'd1;
            bus.mul_z <= bus.mul_z + {11'd0, m_bit};
        end
    end

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int stall,
                           input logic pulse, output logic [PW-1:0] res, output int lat,
                           output int en_cnt, output int clr_cnt, output logic stable,
                           output logic idle_after);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        en_cnt  = 0;
        clr_cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        if (bus.mul_en)  en_cnt++;
        if (bus.mul_clr) clr_cnt++;
        while (!bus.res_valid && lat < 6000) begin
            @(negedge clk);
            lat++;
            if (bus.mul_en)  en_cnt++;
            if (bus.mul_clr) clr_cnt++;
        end
        res    = bus.res_z;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin
                bus.req_valid = i[0];
                bus.req_a     = 6'd7;
                bus.req_b     = 6'd7;
            end
            @(negedge clk);
            if (bus.res_z !== res || bus.req_ready !== 1'b0 || bus.res_valid !== 1'b1) stable = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        idle_after = (bus.res_valid === 1'b0) && (bus.busy === 1'b0) && (bus.req_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.busy, bus.mul_clr, bus.mul_en, bus.res_valid} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=10000",
                     {bus.req_ready, bus.busy, bus.mul_clr, bus.mul_en, bus.res_valid});
        end
        checks++;
        if ({bus.mul_a, bus.mul_b, bus.res_z} !== 24'd0) begin
            failures++;
            $display("FAIL reset_data got=%h want=0", {bus.mul_a, bus.mul_b, bus.res_z});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scale();
        logic [PW-1:0] res;
        int lat, en, clr;
        logic st, idle;
        run_txn(6'd63, 6'd63, 0, 1'b0, res, lat, en, clr, st, idle);
        checks++;
        if (res !== 12'd3969) begin failures++; $display("FAIL full_res got=%0d want=3969", res); end
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("FAIL full_lat got=%0d want=%0d", lat, FULL_LAT); end
        checks++;
        if (en != 4096) begin failures++; $display("FAIL full_en_cycles got=%0d want=4096", en); end
        checks++;
        if (clr != 1) begin failures++; $display("FAIL full_clr_cycles got=%0d want=1", clr); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL full_release got=%b want=1", idle); end
    endtask

    task automatic test_back_to_back();
        int n, rdy_bad;
        bus.res_ready = 1'b1;
        bus.req_a = 6'd5;
        bus.req_b = 6'd12;
        bus.req_valid = 1'b1;
        n = 0;
        rdy_bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.req_ready !== 1'b0) rdy_bad++;
        end while (!bus.res_valid && n < 6000);
        checks++;
        if (bus.res_z !== 12'd60) begin failures++; $display("FAIL b2b_res1 got=%0d want=60", bus.res_z); end
        checks++;
        if (n != FULL_LAT) begin failures++; $display("FAIL b2b_lat1 got=%0d want=%0d", n, FULL_LAT); end
        checks++;
        if (rdy_bad != 0) begin failures++; $display("FAIL b2b_ready_low got=%0d want=0", rdy_bad); end
        bus.req_a = 6'd1;
        bus.req_b = 6'd1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.res_valid} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_turnaround got=%b want=10", {bus.req_ready, bus.res_valid});
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 6000);
        checks++;
        if (bus.res_z !== 12'd1) begin failures++; $display("FAIL b2b_res2 got=%0d want=1", bus.res_z); end
        checks++;
        if (n != FULL_LAT) begin failures++; $display("FAIL b2b_lat2 got=%0d want=%0d", n, FULL_LAT); end
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [PW-1:0] res;
        int lat, en, clr;
        logic st, idle;
        run_txn(6'd40, 6'd33, 100, 1'b1, res, lat, en, clr, st, idle);
        checks++;
        if (res !== 12'd1320) begin failures++; $display("FAIL hold_res got=%0d want=1320", res); end
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL hold_stable got=%b want=1", st); end
        checks++;
        if (idle !== 1'b1) begin failures++; $display("FAIL hold_release got=%b want=1", idle); end
        checks++;
        if ({bus.mul_a, bus.mul_b} !== {6'd40, 6'd33}) begin
            failures++;
            $display("FAIL hold_no_relatch got=%0d,%0d want=40,33", bus.mul_a, bus.mul_b);
        end
    endtask

    task automatic test_abort();
        logic [PW-1:0] res;
        int lat, en, clr, runs;
        logic st, idle;
        bus.req_a = 6'd63;
        bus.req_b = 6'd63;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        runs = 0;
        for (int i = 0; i < 3000 && runs < 2000; i++) begin
            @(negedge clk);
            if (bus.mul_en) runs++;
        end
        checks++;
        if (runs != 2000) begin failures++; $display("FAIL abort_reach_run got=%0d want=2000", runs); end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.busy, bus.mul_clr, bus.mul_en, bus.res_valid} !== 5'b10000) begin
            failures++;
            $display("FAIL abort_ctrl got=%b want=10000",
                     {bus.req_ready, bus.busy, bus.mul_clr, bus.mul_en, bus.res_valid});
        end
        checks++;
        if ({bus.mul_a, bus.mul_b, bus.res_z} !== 24'd0) begin
            failures++;
            $display("FAIL abort_data got=%h want=0", {bus.mul_a, bus.mul_b, bus.res_z});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(6'd2, 6'd3, 0, 1'b0, res, lat, en, clr, st, idle);
        checks++;
        if (res !== 12'd6) begin failures++; $display("FAIL abort_next_res got=%0d want=6", res); end
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("FAIL abort_next_lat got=%0d want=%0d", lat, FULL_LAT); end
    endtask

    task automatic test_zero();
        logic [PW-1:0] res;
        int lat, en, clr;
        logic st, idle;
        run_txn(6'd0, 6'd17, 0, 1'b0, res, lat, en, clr, st, idle);
        checks++;
        if (res !== 12'd0) begin failures++; $display("FAIL zero_res got=%0d want=0", res); end
`ifdef DSC_MUL_CTRL_ZERO_SKIP_EN
        checks++;
        if (lat != 1) begin failures++; $display("FAIL zero_lat got=%0d want=1", lat); end
        checks++;
        if (en != 0 || clr != 0) begin failures++; $display("FAIL zero_no_run got=en%0d/clr%0d want=0/0", en, clr); end
`else
        checks++;
        if (lat != FULL_LAT) begin failures++; $display("FAIL zero_lat got=%0d want=%0d", lat, FULL_LAT); end
        checks++;
        if (en != 4096) begin failures++; $display("FAIL zero_en_cycles got=%0d want=4096", en); end
`endif
    endtask

    task automatic test_random();
        logic [PW-1:0] res;
        logic [W-1:0] a, b;
        int lat, en, clr;
        logic st, idle;
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom_range(0, 63));
            b = W'($urandom_range(0, 63));
            run_txn(a, b, $urandom_range(0, 3), 1'b0, res, lat, en, clr, st, idle);
            checks++;
            if (res !== PW'(int'(a) * int'(b))) begin
                failures++;
                $display("FAIL rand_res[%0d] a=%0d b=%0d got=%0d want=%0d", i, a, b, res, int'(a) * int'(b));
            end
            checks++;
            if (idle !== 1'b1 || st !== 1'b1) begin
                failures++;
                $display("FAIL rand_handshake[%0d] got=%b%b want=11", i, idle, st);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_full_scale();
        test_back_to_back();
        test_hold();
        test_abort();
        test_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
